sim_monitor: RTL

Synthesizable end-of-simulation monitor for the CPU top level. It snoops data-memory writes, keeps a shadow of the test-result region and the sim-end word, and counts run cycles. It detects program completion or a watchdog timeout, then checks the shadow against a loaded golden table one entry per cycle and reports pass/fail, error count and per-entry mismatch events. It generalises fixed-address, single-word end detection to a parametrised address map, byte-strobed writes and in-hardware checking.

---
 rtl/sim_monitor.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sim_monitor.sv
// End-of-simulation monitor: snoops DM writes into a shadow region, detects completion or
// watchdog timeout, then checks the shadow against a golden table. Watchdog enabled by SIM_MONITOR_WATCHDOG_EN.
module sim_monitor #(
    parameter int                ADDR_W       = 14,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] SIM_END_ADDR = 'h3fff,
    parameter logic [DATA_W-1:0] SIM_END_CODE = '1,
    parameter logic [ADDR_W-1:0] TEST_START   = 'h2000,
    parameter int                GOLDEN_DEPTH = 64,
    parameter int                MAX_CYCLE    = 100000,
    parameter int                CNT_W        = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic [DATA_W/8-1:0]                wr_strb,
    input  logic                               gld_we,
    input  logic [$clog2(GOLDEN_DEPTH)-1:0]    gld_idx,
    input  logic [DATA_W-1:0]                  gld_data,
    input  logic [$clog2(GOLDEN_DEPTH+1)-1:0]  gld_num,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               timeout,
    output logic [$clog2(GOLDEN_DEPTH+1)-1:0]  err_cnt,
    output logic [CNT_W-1:0]                   total_cycle,
    output logic                               mm_valid,
    output logic [$clog2(GOLDEN_DEPTH)-1:0]    mm_idx,
    output logic [DATA_W-1:0]                  mm_got,
    output logic [DATA_W-1:0]                  mm_exp
);

    localparam int IDX_W  = $clog2(GOLDEN_DEPTH);
    localparam int NUM_W  = $clog2(GOLDEN_DEPTH + 1);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_shadow [GOLDEN_DEPTH];
    logic [DATA_W-1:0]  r_golden [GOLDEN_DEPTH];
    logic [DATA_W-1:0]  r_end_word;
    logic [NUM_W-1:0]   r_n;
    logic [NUM_W-1:0]   r_idx;
    logic [NUM_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_total_cycle;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_timeout;
    logic               r_mm_valid;
    logic [IDX_W-1:0]   r_mm_idx;
    logic [DATA_W-1:0]  r_mm_got;
    logic [DATA_W-1:0]  r_mm_exp;

    logic [DATA_W-1:0]  w_mask;
    logic [ADDR_W-1:0]  w_off;
    logic [IDX_W-1:0]   w_wr_sel;
    logic               w_in_test;
    logic               w_is_end;
    logic               w_end_hit;
    logic               w_wd_hit;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [NUM_W-1:0]   w_n_clamp;
    logic [IDX_W-1:0]   w_sel;
    logic               w_mismatch;
    logic               w_last;
    logic [NUM_W-1:0]   w_err_next;

    always_comb begin
        w_mask = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            w_mask[8*b +: 8] = {8{wr_strb[b]}};
        end
    end

    assign w_off     = wr_addr - TEST_START;
    assign w_wr_sel  = w_off[IDX_W-1:0];
    assign w_in_test = (wr_addr >= TEST_START) && ({1'b0, w_off} < (ADDR_W+1)'(GOLDEN_DEPTH));
    assign w_is_end  = (wr_addr == SIM_END_ADDR);

    // End-hit looks at the registered end word, so a code assembled from partial writes still counts.
    assign w_end_hit = (r_end_word == SIM_END_CODE);
    assign w_cnt_inc = r_total_cycle + CNT_W'(1);

`ifdef SIM_MONITOR_WATCHDOG_EN
    assign w_wd_hit = (w_cnt_inc == CNT_W'(MAX_CYCLE));
`else
    assign w_wd_hit = 1'b0;
`endif

    assign w_n_clamp  = (int'(gld_num) > GOLDEN_DEPTH) ? NUM_W'(GOLDEN_DEPTH) : gld_num;
    assign w_sel      = r_idx[IDX_W-1:0];
    assign w_mismatch = (r_n != '0) && (r_shadow[w_sel] != r_golden[w_sel]);
    assign w_last     = (r_n == '0) || ((r_idx + NUM_W'(1)) == r_n);
    assign w_err_next = r_err_cnt + NUM_W'(w_mismatch);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < GOLDEN_DEPTH; i++) begin
                r_golden[i] <= '0;
            end
        end else if (r_state == S_IDLE && gld_we && (int'(gld_idx) < GOLDEN_DEPTH)) begin
            r_golden[gld_idx] <= gld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < GOLDEN_DEPTH; i++) begin
                r_shadow[i] <= '0;
            end
            r_end_word <= '0;
        end else if (r_state == S_RUN && wr_en) begin
            if (w_in_test) begin
                r_shadow[w_wr_sel] <= (r_shadow[w_wr_sel] & ~w_mask) | (wr_data & w_mask);
            end
            if (w_is_end) begin
                r_end_word <= (r_end_word & ~w_mask) | (wr_data & w_mask);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_n           <= '0;
            r_idx         <= '0;
            r_err_cnt     <= '0;
            r_total_cycle <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_mm_valid    <= 1'b0;
            r_mm_idx      <= '0;
            r_mm_got      <= '0;
            r_mm_exp      <= '0;
        end else begin
            r_mm_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_n       <= w_n_clamp;
                        r_idx     <= '0;
                        r_err_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_total_cycle <= w_cnt_inc;
                    if (w_end_hit) begin
                        r_state <= S_CHECK;
                    end else if (w_wd_hit) begin
                        r_state   <= S_CHECK;
                        r_timeout <= 1'b1;
                    end
                end
                S_CHECK: begin
                    r_err_cnt <= w_err_next;
                    if (w_mismatch) begin
                        r_mm_valid <= 1'b1;
                        r_mm_idx   <= w_sel;
                        r_mm_got   <= r_shadow[w_sel];
                        r_mm_exp   <= r_golden[w_sel];
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !r_timeout && (w_err_next == '0);
                        // A timed-out run reports every entry as failed regardless of compare results.
                        if (r_timeout) begin
                            r_err_cnt <= r_n;
                        end
                    end else begin
                        r_idx <= r_idx + NUM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign err_cnt     = r_err_cnt;
    assign total_cycle = r_total_cycle;
    assign mm_valid    = r_mm_valid;
    assign mm_idx      = r_mm_idx;
    assign mm_got      = r_mm_got;
    assign mm_exp      = r_mm_exp;

endmodule
